// File: rtl/rs_txn_sequencer.sv
// Batch sequencer for encode_rs over an ap_ctrl_hs handshake: issues NUM_TXN starts with at most
// MAX_OUT outstanding, timestamps each issue and reports per-transaction completion latency.
module rs_txn_sequencer #(
  parameter int unsigned NUM_TXN = 8,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned LAT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             finish,
  output logic             busy,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      done_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             err_spurious
);

  localparam int unsigned OW = $clog2(MAX_OUT) + 1;
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [15:0]   LastTxn = 16'(NUM_TXN - 1);
  localparam logic [15:0]   NumTxn  = 16'(NUM_TXN);
  localparam logic [OW-1:0] MaxOut  = OW'(MAX_OUT);
  localparam logic [PW-1:0] LastPtr = PW'(MAX_OUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cycle_q;
  logic [15:0]        issued_q, issued_d;
  logic [15:0]        done_q, done_d;
  logic [OW-1:0]      out_q, out_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LAT_W-1:0]   last_lat_q, last_lat_d;
  logic [LAT_W-1:0]   max_lat_q, max_lat_d;
  logic               err_q, err_d;
  logic [LAT_W-1:0]   ts_fifo_q [MAX_OUT];

  logic             issue;
  logic             pop;
  logic [LAT_W-1:0] lat;

  // ap_start depends only on registered state, so it cannot drop before ap_ready: completions
  // only lower the outstanding count and issued_q moves only on an accepted start.
  assign ap_start = (state_q == StRun) && (issued_q < NumTxn) && (out_q < MaxOut);
  assign issue    = ap_start && ap_ready;
  assign pop      = ap_done && (out_q != '0);
  // Unsigned subtraction keeps latency correct across a cycle-counter wrap.
  assign lat      = cycle_q - ts_fifo_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    done_d     = done_q;
    out_d      = out_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    err_d      = err_q;

    if (issue) begin
      issued_d = issued_q + 16'd1;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      done_d     = done_q + 16'd1;
      rd_ptr_d   = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      last_lat_d = lat;
      max_lat_d  = (lat > max_lat_q) ? lat : max_lat_q;
    end else if (ap_done) begin
      err_d = 1'b1;
    end

    unique case ({issue, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d    = StRun;
          issued_d   = '0;
          done_d     = '0;
          last_lat_d = '0;
          max_lat_d  = '0;
          err_d      = 1'b0;
        end
      end
      StRun: begin
        if (issue && (issued_q == LastTxn)) state_d = StDrain;
      end
      StDrain: begin
        if (pop && (done_q == LastTxn)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cycle_q    <= '0;
      issued_q   <= '0;
      done_q     <= '0;
      out_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_q + 1'b1;
      issued_q   <= issued_d;
      done_q     <= done_d;
      out_q      <= out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_lat_q <= last_lat_d;
      max_lat_q  <= max_lat_d;
      err_q      <= err_d;
    end
  end

  // Timestamp storage needs no reset; entries are only read after being written.
  always_ff @(posedge clock) begin
    if (issue) ts_fifo_q[wr_ptr_q] <= cycle_q;
  end

  assign finish       = (state_q == StDone);
  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign issued_cnt   = issued_q;
  assign done_cnt     = done_q;
  assign last_lat     = last_lat_q;
  assign max_lat      = max_lat_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_rs_txn_sequencer.sv
// Directed bench for rs_txn_sequencer (NUM_TXN=8, MAX_OUT=4, LAT_W=32).
module tb_rs_txn_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_start;
  logic        finish;
  logic        busy;
  logic [15:0] issued_cnt;
  logic [15:0] done_cnt;
  logic [31:0] last_lat;
  logic [31:0] max_lat;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  rs_txn_sequencer #(
    .NUM_TXN(8),
    .MAX_OUT(4),
    .LAT_W  (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .finish      (finish),
    .busy        (busy),
    .issued_cnt  (issued_cnt),
    .done_cnt    (done_cnt),
    .last_lat    (last_lat),
    .max_lat     (max_lat),
    .err_spurious(err_spurious)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL rst_ap_start got %0d want 0", ap_start); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL rst_finish got %0d want 0", finish); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy); end
    checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL rst_issued got %0d want 0", issued_cnt); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL rst_done got %0d want 0", done_cnt); end
    checks++; if (max_lat !== 32'd0) begin errors++; $display("FAIL rst_max_lat got %0d want 0", max_lat); end
    checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL rst_err got %0d want 0", err_spurious); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_spurious_idle();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL idle_err got %0d want 1", err_spurious); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL idle_done got %0d want 0", done_cnt); end
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL go_clr_err got %0d want 0", err_spurious); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL go_busy got %0d want 1", busy); end
    checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL go_ap_start got %0d want 1", ap_start); end
    // Abandon this batch before any issue.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  // ap_ready tied high, every issue answered by ap_done exactly 5 cycles later.
  task automatic run_batch(input string tag);
    bit hist [80];
    int ndone = 0;
    bit seen = 1'b0;
    go = 1'b1;
    ap_ready = 1'b1;
    ap_done = 1'b0;
    tick();
    go = 1'b0;
    checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL %s_start got %0d want 1", tag, ap_start); end
    for (int s = 0; s < 80 && !seen; s++) begin
      ap_done = (s >= 5) ? hist[s-5] : 1'b0;
      hist[s] = ap_start;
      if (ap_done) ndone++;
      if (ndone == 8) begin
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL %s_finish_early got %0d want 0", tag, finish); end
        tick();
        ap_done = 1'b0;
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL %s_finish got %0d want 1", tag, finish); end
        seen = 1'b1;
      end else begin
        tick();
      end
    end
    ap_done = 1'b0;
    ap_ready = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout got %0d dones want 8", tag, ndone); end
    checks++; if (issued_cnt !== 16'd8) begin errors++; $display("FAIL %s_issued got %0d want 8", tag, issued_cnt); end
    checks++; if (done_cnt !== 16'd8) begin errors++; $display("FAIL %s_done got %0d want 8", tag, done_cnt); end
    checks++; if (last_lat !== 32'd5) begin errors++; $display("FAIL %s_last_lat got %0d want 5", tag, last_lat); end
    checks++; if (max_lat !== 32'd5) begin errors++; $display("FAIL %s_max_lat got %0d want 5", tag, max_lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0d want 0", tag, busy); end
    checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL %s_err got %0d want 0", tag, err_spurious); end
  endtask

  task automatic test_done_state();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL done_err got %0d want 1", err_spurious); end
    checks++; if (done_cnt !== 16'd8) begin errors++; $display("FAIL done_hold got %0d want 8", done_cnt); end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL done_finish got %0d want 1", finish); end
    go = 1'b1;
    tick();
    go = 1'b0;
    // Now at cycle k=0 of a new batch.
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL rego_finish got %0d want 0", finish); end
    checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL rego_err got %0d want 0", err_spurious); end
    checks++; if (max_lat !== 32'd0) begin errors++; $display("FAIL rego_max got %0d want 0", max_lat); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL rego_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL stall_start%0d got %0d want 1", i, ap_start); end
      checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL stall_iss%0d got %0d want 0", i, issued_cnt); end
      tick();
    end
    ap_ready = 1'b1;
    tick();
    checks++; if (issued_cnt !== 16'd1) begin errors++; $display("FAIL stall_accept got %0d want 1", issued_cnt); end
  endtask

  task automatic test_max_out();
    tick();
    tick();
    tick();
    // k=7: four outstanding, no completions yet
    checks++; if (issued_cnt !== 16'd4) begin errors++; $display("FAIL max_iss got %0d want 4", issued_cnt); end
    checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL max_start got %0d want 0", ap_start); end
    tick();
    tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    // k=10: first done at k=9 for issue at k=3
    checks++; if (last_lat !== 32'd6) begin errors++; $display("FAIL max_lat1 got %0d want 6", last_lat); end
    checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL max_restart got %0d want 1", ap_start); end
    tick();
    checks++; if (issued_cnt !== 16'd5) begin errors++; $display("FAIL max_one_more got %0d want 5", issued_cnt); end
    checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL max_refull got %0d want 0", ap_start); end
  endtask

  task automatic test_same_cycle();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    ap_ready = 1'b0;
    checks++; if (last_lat !== 32'd7) begin errors++; $display("FAIL sc_lat_b got %0d want 7", last_lat); end
    tick();
    ap_ready = 1'b1;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    // k=14: issue at k=13 alongside completion of the k=5 issue
    checks++; if (issued_cnt !== 16'd6) begin errors++; $display("FAIL sc_iss got %0d want 6", issued_cnt); end
    checks++; if (done_cnt !== 16'd3) begin errors++; $display("FAIL sc_done got %0d want 3", done_cnt); end
    checks++; if (last_lat !== 32'd8) begin errors++; $display("FAIL sc_lat got %0d want 8", last_lat); end
    checks++; if (ap_start !== 1'b1) begin errors++; $display("FAIL sc_out_const got %0d want 1", ap_start); end
  endtask

  task automatic test_drain_reset();
    tick();
    ap_done = 1'b1;
    checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL dr_full got %0d want 0", ap_start); end
    tick();
    ap_done = 1'b0;
    tick();
    checks++; if (issued_cnt !== 16'd8) begin errors++; $display("FAIL dr_iss got %0d want 8", issued_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dr_busy got %0d want 1", busy); end
    ap_done = 1'b1;
    tick();
    tick();
    ap_done = 1'b0;
    // k=19: DRAIN with two outstanding
    checks++; if (done_cnt !== 16'd6) begin errors++; $display("FAIL dr_done got %0d want 6", done_cnt); end
    checks++; if (last_lat !== 32'd5) begin errors++; $display("FAIL dr_last got %0d want 5", last_lat); end
    checks++; if (max_lat !== 32'd9) begin errors++; $display("FAIL dr_max got %0d want 9", max_lat); end
    checks++; if (ap_start !== 1'b0) begin errors++; $display("FAIL dr_start got %0d want 0", ap_start); end
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dr_go_ign got %0d want 1", busy); end
    checks++; if (done_cnt !== 16'd6) begin errors++; $display("FAIL dr_go_done got %0d want 6", done_cnt); end
    reset = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %0d want 0", busy); end
    checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL ar_iss got %0d want 0", issued_cnt); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL ar_done got %0d want 0", done_cnt); end
    checks++; if (max_lat !== 32'd0) begin errors++; $display("FAIL ar_max got %0d want 0", max_lat); end
    checks++; if (last_lat !== 32'd0) begin errors++; $display("FAIL ar_last got %0d want 0", last_lat); end
    reset = 1'b1;
    tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL ar_late_done got %0d want 1", err_spurious); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL ar_late_cnt got %0d want 0", done_cnt); end
    run_batch("rerun");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spurious_idle();
    run_batch("b2b");
    test_done_state();
    test_ready_stall();
    test_max_out();
    test_same_cycle();
    test_drain_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
